// File: rtl/io_key_switch.sv
`default_nettype none
// ============================================================================
//  Module      : io_key_switch
//  Description : Memory-mapped KEY/SW input peripheral. Two-flop synchronises
//                and debounces every pin, exposes stable levels, sticky
//                key-press flags (write-1-to-clear), interrupt enables and a
//                registered key interrupt. Reads are side-effect free.
//  Revision    : 1.0  initial release
// ============================================================================
module io_key_switch #(
    parameter int unsigned      DBITS           = 32,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter int unsigned      CNT_BITS        = 20,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KEDGE      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000114
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic             wrEn,
    input  logic [DBITS-1:0] wrData,
    output logic             hit,
    output logic [DBITS-1:0] rdData,
    output logic             keyIrq
);

    // Pins [3:0] are keys, [13:4] are switches.
    localparam int unsigned          c_NPIN     = 14;
    localparam logic [CNT_BITS-1:0]  c_CNT_MAX  = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    // Keys idle high on the board, so their synchronisers start "released".
    localparam logic [c_NPIN-1:0]    c_SYNC_RST = {10'b0, 4'b1111};

    logic [c_NPIN-1:0]   sync1_q;
    logic [c_NPIN-1:0]   sync2_q;
    logic [c_NPIN-1:0]   stable_q;
    logic [CNT_BITS-1:0] cnt_q [c_NPIN];
    logic [c_NPIN-1:0]   w_lvl;

    logic [3:0] keyPrev_q;
    logic [3:0] keyEdge_q;
    logic [3:0] keyEdge_d;
    logic [3:0] keyIe_q;
    logic [3:0] keyIe_d;
    logic       keyIrq_q;
    logic [3:0] w_rise;

    // Only the low nibble of store data is architecturally meaningful.
    logic w_unused;
    assign w_unused = ^wrData[DBITS-1:4];

    // Synchronised level with keys flipped so that 1 means pressed.
    assign w_lvl = {sync2_q[c_NPIN-1:4], ~sync2_q[3:0]};

    // Two-flop synchroniser for every asynchronous board pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= c_SYNC_RST;
            sync2_q <= c_SYNC_RST;
        end else begin
            sync1_q <= {SW, KEY};
            sync2_q <= sync1_q;
        end
    end

    // Per-pin debounce: a level must differ from stable for DEBOUNCE_CYCLES
    // consecutive edges; any return to the stable value restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < c_NPIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NPIN; i++) begin
                if (w_lvl[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == c_CNT_MAX) begin
                    stable_q[i] <= w_lvl[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is a 0->1 step of the debounced key level seen one edge late.
    assign w_rise = stable_q[3:0] & ~keyPrev_q;

    // Next-state for sticky flags and enables; a fresh rise beats a clear.
    always_comb begin
        keyEdge_d = keyEdge_q | w_rise;
        keyIe_d   = keyIe_q;
        if (wrEn && (addr == ADDR_KEDGE)) begin
            keyEdge_d = (keyEdge_q & ~wrData[3:0]) | w_rise;
        end
        if (wrEn && (addr == ADDR_KCTRL)) begin
            keyIe_d = wrData[3:0];
        end
    end

    // Flag/enable registers; the interrupt is computed from next-state so it
    // changes on the same edge as the registers it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            keyPrev_q <= '0;
            keyEdge_q <= '0;
            keyIe_q   <= '0;
            keyIrq_q  <= 1'b0;
        end else begin
            keyPrev_q <= stable_q[3:0];
            keyEdge_q <= keyEdge_d;
            keyIe_q   <= keyIe_d;
            keyIrq_q  <= |(keyEdge_d & keyIe_d);
        end
    end

    assign keyIrq = keyIrq_q;

    // Read mux over registered state; full-address compare, no side effects.
    always_comb begin
        hit    = 1'b0;
        rdData = '0;
        if (addr == ADDR_KEY) begin
            hit    = 1'b1;
            rdData = DBITS'(stable_q[3:0]);
        end else if (addr == ADDR_SW) begin
            hit    = 1'b1;
            rdData = DBITS'(stable_q[c_NPIN-1:4]);
        end else if (addr == ADDR_KEDGE) begin
            hit    = 1'b1;
            rdData = DBITS'(keyEdge_q);
        end else if (addr == ADDR_KCTRL) begin
            hit    = 1'b1;
            rdData = DBITS'(keyIe_q);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_key_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_key_switch
//  Description : Directed self-checking bench for io_key_switch with a
//                debounce length of 4 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_key_switch;

    localparam logic [31:0] c_A_KEY   = 32'hF0000010;
    localparam logic [31:0] c_A_SW    = 32'hF0000014;
    localparam logic [31:0] c_A_KEDGE = 32'hF0000110;
    localparam logic [31:0] c_A_KCTRL = 32'hF0000114;
    localparam logic [31:0] c_A_NONE  = 32'hF0000018;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [31:0] addr = '0;
    logic        wrEn = 1'b0;
    logic [31:0] wrData = '0;
    logic        hit;
    logic [31:0] rdData;
    logic        keyIrq;

    int total = 0;
    int bad   = 0;

    io_key_switch #(
        .DBITS          (32),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS       (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .SW    (SW),
        .addr  (addr),
        .wrEn  (wrEn),
        .wrData(wrData),
        .hit   (hit),
        .rdData(rdData),
        .keyIrq(keyIrq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, ending 1 ns after the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational read; also checks that mapped addresses assert hit.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdData, exp);
        chk({tag, "_hit"}, {31'b0, hit}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wrData = d;
        wrEn   = 1'b1;
        tick(1);
        wrEn   = 1'b0;
        wrData = '0;
    endtask

    initial begin
        // Reset state
        tick(2);
        reset = 1'b0;
        rd("rst_key",   c_A_KEY,   32'h0);
        rd("rst_sw",    c_A_SW,    32'h0);
        rd("rst_kedge", c_A_KEDGE, 32'h0);
        rd("rst_kctrl", c_A_KCTRL, 32'h0);
        chk("rst_irq", {31'b0, keyIrq}, 32'h0);

        // Debounce timing: stable on edge 6, flag on edge 7
        KEY = 4'b1110;
        tick(5);
        rd("deb_e5_key", c_A_KEY, 32'h0);
        tick(1);
        rd("deb_e6_key", c_A_KEY, 32'h1);
        rd("deb_e6_kedge", c_A_KEDGE, 32'h0);
        tick(1);
        rd("deb_e7_kedge", c_A_KEDGE, 32'h1);
        chk("deb_irq_off", {31'b0, keyIrq}, 32'h0);

        // Release sets no flag
        KEY = 4'hF;
        tick(7);
        rd("rel_key", c_A_KEY, 32'h0);
        rd("rel_kedge", c_A_KEDGE, 32'h1);

        // Bounce reject on KEY[1]
        KEY = 4'b1101; tick(3);
        KEY = 4'b1111; tick(1);
        KEY = 4'b1101; tick(3);
        KEY = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rd("bnc_key", c_A_KEY, 32'h0);
            tick(1);
        end
        rd("bnc_kedge", c_A_KEDGE, 32'h1);

        // Build keyEdge = 0101 with a KEY[2] press
        KEY = 4'b1011; tick(7);
        KEY = 4'hF;    tick(7);
        rd("w1c_pre", c_A_KEDGE, 32'h5);
        wr(c_A_KEDGE, 32'h4);
        rd("w1c_clr2", c_A_KEDGE, 32'h1);

        // Clear of bit 0 on the very edge its new rise lands: rise wins
        KEY = 4'b1110; tick(6);
        rd("w1c_e6_key", c_A_KEY, 32'h1);
        wr(c_A_KEDGE, 32'h1);
        rd("w1c_race", c_A_KEDGE, 32'h1);
        KEY = 4'hF; tick(7);

        // Interrupt enable on bit 1 only
        wr(c_A_KCTRL, 32'h2);
        rd("irq_kctrl", c_A_KCTRL, 32'h2);
        chk("irq_en_b1", {31'b0, keyIrq}, 32'h0);
        KEY = 4'b1110; tick(7);
        chk("irq_k0", {31'b0, keyIrq}, 32'h0);
        KEY = 4'hF; tick(7);
        KEY = 4'b1101; tick(6);
        chk("irq_k1_e6", {31'b0, keyIrq}, 32'h0);
        tick(1);
        chk("irq_k1_e7", {31'b0, keyIrq}, 32'h1);
        rd("irq_kedge", c_A_KEDGE, 32'h3);
        KEY = 4'hF; tick(7);
        chk("irq_hold", {31'b0, keyIrq}, 32'h1);
        wr(c_A_KEDGE, 32'h2);
        chk("irq_clr", {31'b0, keyIrq}, 32'h0);
        rd("irq_kedge2", c_A_KEDGE, 32'h1);

        // Switches and read-only behaviour
        SW = 10'h2A5;
        tick(5);
        rd("sw_e5", c_A_SW, 32'h0);
        tick(1);
        rd("sw_e6", c_A_SW, 32'h2A5);
        wr(c_A_SW, 32'h0);
        rd("ro_sw", c_A_SW, 32'h2A5);
        wr(c_A_KEY, 32'hF);
        rd("ro_key", c_A_KEY, 32'h0);
        wr(c_A_NONE, 32'hF);
        rd("ro_kctrl", c_A_KCTRL, 32'h2);
        rd("ro_kedge", c_A_KEDGE, 32'h1);
        addr = c_A_NONE;
        #1;
        chk("unmap_hit", {31'b0, hit}, 32'h0);
        chk("unmap_rd", rdData, 32'h0);

        // Reset in the middle of a KEY[2] debounce
        KEY = 4'b1011; tick(2);
        KEY = 4'hF;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd("mid_key",   c_A_KEY,   32'h0);
        rd("mid_sw",    c_A_SW,    32'h0);
        rd("mid_kedge", c_A_KEDGE, 32'h0);
        rd("mid_kctrl", c_A_KCTRL, 32'h0);
        chk("mid_irq", {31'b0, keyIrq}, 32'h0);
        tick(10);
        rd("mid_after", c_A_KEDGE, 32'h0);
        rd("mid_swback", c_A_SW, 32'h2A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
